// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX MEM stage.
package dlx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RD,
        WAIT_WR
    } mem_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned DEFAULT_MAX_WAIT = 255;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface mem_stage_if #(
    parameter int unsigned AW = 32
);
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_we;
    logic          d_req;
    logic          d_ack;
    logic [31:0]   d_rdata;

    modport master (output d_addr, d_wdata, d_we, d_req, input d_ack, d_rdata);
    modport slave  (input d_addr, d_wdata, d_we, d_req, output d_ack, d_rdata);
endinterface

// File: rtl/mem_bus_fsm.sv
// Bus handshake FSM: wait-state counting, timeout abort, sticky error, stall generation.
// Optional one-entry store buffer enabled by defining MEM_STORE_BUFFER_EN.
module mem_bus_fsm
    import dlx_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int unsigned AW       = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        access,
    input  logic        is_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    mem_stage_if.master bus,
    output logic        stall,
    output logic        timeout,
    output logic        bus_err
);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q;
    logic          cur_valid, cur_we;
    logic [31:0]   cur_addr, cur_wdata;
    logic          waiting, req, done;

`ifdef MEM_STORE_BUFFER_EN
    logic        sb_valid_q, sb_valid_d;
    logic [31:0] sb_addr_q, sb_data_q;
    logic        drain_done, sb_capture;

    // A full buffer always owns the bus; loads only start once it has drained.
    assign cur_valid = sb_valid_q | (access & is_load);
    assign cur_we    = sb_valid_q;
    assign cur_addr  = sb_valid_q ? sb_addr_q : addr;
    assign cur_wdata = sb_valid_q ? sb_data_q : wdata;
`else
    assign cur_valid = access;
    assign cur_we    = ~is_load;
    assign cur_addr  = addr;
    assign cur_wdata = wdata;
`endif

    assign waiting = (state_q != IDLE);
    assign timeout = waiting && (cnt_q == CW'(MAX_WAIT));
    assign req     = waiting ? ~timeout : cur_valid;
    assign done    = (req & bus.d_ack) | timeout;

    assign bus.d_req   = req;
    assign bus.d_we    = req & cur_we;
    assign bus.d_addr  = AW'(cur_addr);
    assign bus.d_wdata = cur_wdata;
    assign bus_err     = bus_err_q;

`ifdef MEM_STORE_BUFFER_EN
    assign drain_done = sb_valid_q & done;

    always_comb begin
        stall = 1'b0;
        if (access && is_load) begin
            stall = sb_valid_q | ~done;
        end else if (access) begin
            stall = sb_valid_q & ~drain_done;
        end
    end

    assign sb_capture = access & ~is_load & ~stall;

    always_comb begin
        sb_valid_d = sb_valid_q;
        if (sb_capture) begin
            sb_valid_d = 1'b1;
        end else if (drain_done) begin
            sb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sb_valid_q <= 1'b0;
            sb_addr_q  <= '0;
            sb_data_q  <= '0;
        end else begin
            sb_valid_q <= sb_valid_d;
            if (sb_capture) begin
                sb_addr_q <= addr;
                sb_data_q <= wdata;
            end
        end
    end
`else
    assign stall = access & ~done;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cur_valid && !bus.d_ack) begin
                    state_d = cur_we ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_RD, WAIT_WR: begin
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// DLX MEM stage: bus access via mem_bus_fsm, MEM->WB registers and EX forwarding.
// Store buffering is optional via MEM_STORE_BUFFER_EN.
module mem_stage
    import dlx_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int unsigned AW       = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_MEM,
    input  logic [31:0] ALU_out_MEM,
    input  logic [31:0] store_data_MEM,
    input  logic        d_write_enable_MEM,
    input  logic        d_load_enable_MEM,
    input  logic [4:0]  Rd_MEM,
    mem_stage_if.master dbus,
    output logic        stall_MEM,
    output logic [31:0] fwd_value,
    output logic [4:0]  fwd_rd,
    output logic [31:0] wb_data_WB,
    output logic [4:0]  rd_WB,
    output logic        wb_en_WB,
    output logic        bus_err
);
    logic        is_mem, access, timeout, fwd_ok;
    logic [31:0] wb_data_d;
    logic [4:0]  rd_d;
    logic        wb_en_d;

    assign is_mem = d_write_enable_MEM | d_load_enable_MEM;
    assign access = valid_MEM & is_mem;

    mem_bus_fsm #(
        .MAX_WAIT (MAX_WAIT),
        .AW       (AW)
    ) u_bus_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .access  (access),
        .is_load (d_load_enable_MEM),
        .addr    (ALU_out_MEM),
        .wdata   (store_data_MEM),
        .bus     (dbus),
        .stall   (stall_MEM),
        .timeout (timeout),
        .bus_err (bus_err)
    );

    // Loads forward nothing: the address must never reach EX as a result.
    assign fwd_ok    = valid_MEM & ~is_mem & (Rd_MEM != REG_ZERO);
    assign fwd_rd    = fwd_ok ? Rd_MEM : REG_ZERO;
    assign fwd_value = fwd_ok ? ALU_out_MEM : 32'd0;

    // Stalled cycles hand WB a bubble so nothing is written twice.
    always_comb begin
        wb_data_d = 32'd0;
        rd_d      = REG_ZERO;
        wb_en_d   = 1'b0;
        if (valid_MEM && !stall_MEM) begin
            if (d_load_enable_MEM) begin
                if (!timeout) begin
                    wb_data_d = dbus.d_rdata;
                    rd_d      = Rd_MEM;
                    wb_en_d   = (Rd_MEM != REG_ZERO);
                end
            end else if (!d_write_enable_MEM) begin
                wb_data_d = ALU_out_MEM;
                rd_d      = Rd_MEM;
                wb_en_d   = (Rd_MEM != REG_ZERO);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_data_WB <= 32'd0;
            rd_WB      <= REG_ZERO;
            wb_en_WB   <= 1'b0;
        end else begin
            wb_data_WB <= wb_data_d;
            rd_WB      <= rd_d;
            wb_en_WB   <= wb_en_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with MAX_WAIT=4.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_MEM;
    logic [31:0] ALU_out_MEM;
    logic [31:0] store_data_MEM;
    logic        d_write_enable_MEM;
    logic        d_load_enable_MEM;
    logic [4:0]  Rd_MEM;
    logic        stall_MEM;
    logic [31:0] fwd_value;
    logic [4:0]  fwd_rd;
    logic [31:0] wb_data_WB;
    logic [4:0]  rd_WB;
    logic        wb_en_WB;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_stage_if #(.AW(32)) dbus ();

    mem_stage #(
        .MAX_WAIT (4),
        .AW       (32)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .valid_MEM          (valid_MEM),
        .ALU_out_MEM        (ALU_out_MEM),
        .store_data_MEM     (store_data_MEM),
        .d_write_enable_MEM (d_write_enable_MEM),
        .d_load_enable_MEM  (d_load_enable_MEM),
        .Rd_MEM             (Rd_MEM),
        .dbus               (dbus),
        .stall_MEM          (stall_MEM),
        .fwd_value          (fwd_value),
        .fwd_rd             (fwd_rd),
        .wb_data_WB         (wb_data_WB),
        .rd_WB              (rd_WB),
        .wb_en_WB           (wb_en_WB),
        .bus_err            (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; combinational checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                          input logic st, input logic ld, input logic [4:0] rd);
        valid_MEM          = v;
        ALU_out_MEM        = alu;
        store_data_MEM     = sd;
        d_write_enable_MEM = st;
        d_load_enable_MEM  = ld;
        Rd_MEM             = rd;
    endtask

    initial begin
        reset_n    = 1'b0;
        dbus.d_ack = 1'b0;
        dbus.d_rdata = 32'd0;
        set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        chk("rst_wb_en", 32'(wb_en_WB), 32'd0);
        chk("rst_wb_data", wb_data_WB, 32'd0);
        chk("rst_rd_wb", 32'(rd_WB), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_d_req", 32'(dbus.d_req), 32'd0);
        chk("rst_d_we", 32'(dbus.d_we), 32'd0);
        chk("rst_stall", 32'(stall_MEM), 32'd0);
        reset_n = 1'b1;

        // ADD r5 = 0x1234
        tick();
        set_op(1'b1, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 5'd5);
        #1;
        chk("add_fwd_rd", 32'(fwd_rd), 32'd5);
        chk("add_fwd_value", fwd_value, 32'h0000_1234);
        chk("add_stall", 32'(stall_MEM), 32'd0);
        chk("add_d_req", 32'(dbus.d_req), 32'd0);
        tick();
        chk("add_wb_data", wb_data_WB, 32'h0000_1234);
        chk("add_rd_wb", 32'(rd_WB), 32'd5);
        chk("add_wb_en", 32'(wb_en_WB), 32'd1);

        // Load 0x100 -> r7, ack after 3 stalled cycles
        set_op(1'b1, 32'h0000_0100, 32'd0, 1'b0, 1'b1, 5'd7);
        dbus.d_ack = 1'b0;
        #1;
        chk("ld_stall_c0", 32'(stall_MEM), 32'd1);
        chk("ld_req_c0", 32'(dbus.d_req), 32'd1);
        chk("ld_addr_c0", dbus.d_addr, 32'h0000_0100);
        chk("ld_we_c0", 32'(dbus.d_we), 32'd0);
        chk("ld_fwd_rd_c0", 32'(fwd_rd), 32'd0);
        chk("ld_fwd_val_c0", fwd_value, 32'd0);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk("ld_wb_en_stall", 32'(wb_en_WB), 32'd0);
            #1;
            chk("ld_stall_wait", 32'(stall_MEM), 32'd1);
            chk("ld_req_wait", 32'(dbus.d_req), 32'd1);
            chk("ld_addr_wait", dbus.d_addr, 32'h0000_0100);
            chk("ld_fwd_rd_wait", 32'(fwd_rd), 32'd0);
        end
        tick();
        dbus.d_ack   = 1'b1;
        dbus.d_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_stall_ack", 32'(stall_MEM), 32'd0);
        chk("ld_addr_ack", dbus.d_addr, 32'h0000_0100);
        chk("ld_fwd_rd_ack", 32'(fwd_rd), 32'd0);
        tick();
        chk("ld_wb_data", wb_data_WB, 32'hDEAD_BEEF);
        chk("ld_rd_wb", 32'(rd_WB), 32'd7);
        chk("ld_wb_en", 32'(wb_en_WB), 32'd1);

        // Store 0x200 <- 0xA5A5A5A5, zero-wait ack
        set_op(1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 1'b0, 5'd9);
        dbus.d_ack = 1'b1;
        #1;
        chk("st_we", 32'(dbus.d_we), 32'd1);
        chk("st_req", 32'(dbus.d_req), 32'd1);
        chk("st_addr", dbus.d_addr, 32'h0000_0200);
        chk("st_wdata", dbus.d_wdata, 32'hA5A5_A5A5);
        chk("st_stall", 32'(stall_MEM), 32'd0);
        chk("st_fwd_rd", 32'(fwd_rd), 32'd0);
        tick();
        chk("st_wb_en", 32'(wb_en_WB), 32'd0);
        chk("st_rd_wb", 32'(rd_WB), 32'd0);

        // Load and store together behave as a load
        set_op(1'b1, 32'h0000_0240, 32'h1111_1111, 1'b1, 1'b1, 5'd3);
        dbus.d_rdata = 32'h1234_5678;
        #1;
        chk("ldst_we", 32'(dbus.d_we), 32'd0);
        chk("ldst_stall", 32'(stall_MEM), 32'd0);
        tick();
        chk("ldst_wb_data", wb_data_WB, 32'h1234_5678);
        chk("ldst_rd_wb", 32'(rd_WB), 32'd3);
        chk("ldst_wb_en", 32'(wb_en_WB), 32'd1);

        // ALU result to r0
        set_op(1'b1, 32'h0000_FFFF, 32'd0, 1'b0, 1'b0, 5'd0);
        dbus.d_ack = 1'b0;
        #1;
        chk("r0_fwd_rd", 32'(fwd_rd), 32'd0);
        chk("r0_fwd_value", fwd_value, 32'd0);
        tick();
        chk("r0_wb_en", 32'(wb_en_WB), 32'd0);

        // Bubble
        set_op(1'b0, 32'h0000_0055, 32'd0, 1'b0, 1'b1, 5'd3);
        #1;
        chk("bub_fwd_rd", 32'(fwd_rd), 32'd0);
        chk("bub_req", 32'(dbus.d_req), 32'd0);
        chk("bub_stall", 32'(stall_MEM), 32'd0);
        tick();
        chk("bub_wb_en", 32'(wb_en_WB), 32'd0);

        // Load with no ack: 4 wait cycles, then abort
        set_op(1'b1, 32'h0000_0300, 32'd0, 1'b0, 1'b1, 5'd4);
        #1;
        chk("to_stall_idle", 32'(stall_MEM), 32'd1);
        chk("to_req_idle", 32'(dbus.d_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("to_req_wait", 32'(dbus.d_req), 32'd1);
            chk("to_stall_wait", 32'(stall_MEM), 32'd1);
            chk("to_err_wait", 32'(bus_err), 32'd0);
        end
        tick();
        #1;
        chk("to_req_drop", 32'(dbus.d_req), 32'd0);
        chk("to_stall_rel", 32'(stall_MEM), 32'd0);
        tick();
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_wb_en", 32'(wb_en_WB), 32'd0);
        chk("to_rd_wb", 32'(rd_WB), 32'd0);
        set_op(1'b1, 32'h0000_0042, 32'd0, 1'b0, 1'b0, 5'd6);
        #1;
        chk("to_req_idle_after", 32'(dbus.d_req), 32'd0);
        tick();
        tick();
        chk("to_bus_err_sticky", 32'(bus_err), 32'd1);
        chk("post_to_wb_data", wb_data_WB, 32'h0000_0042);

        // Reset while in WAIT_RD
        set_op(1'b1, 32'h0000_0400, 32'd0, 1'b0, 1'b1, 5'd8);
        tick();
        #1;
        chk("rw_stall_wait", 32'(stall_MEM), 32'd1);
        chk("rw_req_wait", 32'(dbus.d_req), 32'd1);
        reset_n = 1'b0;
        set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        chk("rw_req", 32'(dbus.d_req), 32'd0);
        chk("rw_stall", 32'(stall_MEM), 32'd0);
        chk("rw_wb_data", wb_data_WB, 32'd0);
        chk("rw_rd_wb", 32'(rd_WB), 32'd0);
        chk("rw_wb_en", 32'(wb_en_WB), 32'd0);
        chk("rw_bus_err", 32'(bus_err), 32'd0);
        reset_n = 1'b1;

        // Back to normal after reset
        set_op(1'b1, 32'h0000_0777, 32'd0, 1'b0, 1'b0, 5'd2);
        tick();
        chk("final_wb_data", wb_data_WB, 32'h0000_0777);
        chk("final_wb_en", 32'(wb_en_WB), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
